// File: rtl/reg_master_if.sv
// Command, byte-link and response signals of the register-protocol initiator.
// master = the reg_master side; slave = command source plus byte link.
interface reg_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_wr_i;
  logic [15:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_rdy_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_timeout_o;

  modport master (
    input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_data_i, tx_ready_i, rx_data_i, rx_rdy_i,
    output cmd_ready_o, tx_data_o, tx_valid_o, rsp_valid_o, rsp_data_o, rsp_timeout_o
  );

  modport slave (
    output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_data_i, tx_ready_i, rx_data_i, rx_rdy_i,
    input  cmd_ready_o, tx_data_o, tx_valid_o, rsp_valid_o, rsp_data_o, rsp_timeout_o
  );
endinterface

// File: rtl/reg_master.sv
// Register-protocol initiator: sends an 8-byte command, then parses the AB + 4-byte reply.
// Optional reply timeout is enabled with `define REG_MASTER_TIMEOUT_EN.
module reg_master #(
  parameter logic [7:0] MAGIC_BYTE = 8'hAA,
  parameter logic [7:0] REPLY_BYTE = 8'hAB
`ifdef REG_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic clk_i,
  input  logic reset_i,
  reg_master_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TX   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RX   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [23:0] rx_buf_q, rx_buf_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [7:0]  tx_byte;

`ifdef REG_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Expiry is detected one cycle early so the timeout response lands
  // exactly TIMEOUT_CYCLES cycles after the final TX byte is taken.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 2);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  always_comb begin
    case (idx_q)
      3'd0:    tx_byte = MAGIC_BYTE;
      3'd1:    tx_byte = {7'b0, wr_q};
      3'd2:    tx_byte = addr_q[7:0];
      3'd3:    tx_byte = addr_q[15:8];
      3'd4:    tx_byte = data_q[7:0];
      3'd5:    tx_byte = data_q[15:8];
      3'd6:    tx_byte = data_q[23:16];
      default: tx_byte = data_q[31:24];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rx_buf_d   = rx_buf_q;
    rsp_data_d = rsp_data_q;
`ifdef REG_MASTER_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: if (bus.cmd_valid_i) begin
        wr_d    = bus.cmd_wr_i;
        addr_d  = bus.cmd_addr_i;
        data_d  = bus.cmd_data_i;
        idx_d   = 3'd0;
        state_d = S_TX;
      end
      S_TX: if (bus.tx_ready_i) begin
        if (idx_q == 3'd7) begin
          idx_d   = 3'd0;
          state_d = S_WAIT;
`ifdef REG_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_WAIT: if (bus.rx_rdy_i && bus.rx_data_i == REPLY_BYTE) begin
        idx_d   = 3'd0;
        state_d = S_RX;
      end
      S_RX: if (bus.rx_rdy_i) begin
        idx_d = idx_q + 3'd1;
        case (idx_q[1:0])
          2'd0: rx_buf_d[7:0]   = bus.rx_data_i;
          2'd1: rx_buf_d[15:8]  = bus.rx_data_i;
          2'd2: rx_buf_d[23:16] = bus.rx_data_i;
          default: begin
            rsp_data_d = {bus.rx_data_i, rx_buf_q};
            state_d    = S_DONE;
`ifdef REG_MASTER_TIMEOUT_EN
            tmo_d      = 1'b0;
`endif
          end
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef REG_MASTER_TIMEOUT_EN
    // An arriving byte always restarts the count, even on the expiry cycle.
    if (state_q == S_WAIT || state_q == S_RX) begin
      if (bus.rx_rdy_i) begin
        cnt_d = '0;
      end else if (cnt_q == TMO_LAST) begin
        state_d    = S_DONE;
        tmo_d      = 1'b1;
        rsp_data_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rx_buf_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rx_buf_q   <= rx_buf_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef REG_MASTER_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign bus.rsp_timeout_o = (state_q == S_DONE) && tmo_q;
`else
  assign bus.rsp_timeout_o = 1'b0;
`endif

  assign bus.cmd_ready_o = (state_q == S_IDLE);
  assign bus.tx_valid_o  = (state_q == S_TX);
  assign bus.tx_data_o   = (state_q == S_TX) ? tx_byte : 8'h00;
  assign bus.rsp_valid_o = (state_q == S_DONE);
  assign bus.rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_reg_master.sv
// Directed bench for reg_master: read, stalled write, junk skip, timeout, reset, back-to-back.
module tb_reg_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;

  reg_master_if bus();

`ifdef REG_MASTER_TIMEOUT_EN
  reg_master #(.TIMEOUT_CYCLES(16)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));
`else
  reg_master dut (.clk_i(clk), .reset_i(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_wr_i    = 1'b0;
    bus.cmd_addr_i  = 16'h0;
    bus.cmd_data_i  = 32'h0;
    bus.tx_ready_i  = 1'b0;
    bus.rx_data_i   = 8'h0;
    bus.rx_rdy_i    = 1'b0;
  endtask

  task automatic send_cmd(input logic wr, input logic [15:0] a, input logic [31:0] d);
    int cyc;
    bus.cmd_wr_i    = wr;
    bus.cmd_addr_i  = a;
    bus.cmd_data_i  = d;
    bus.cmd_valid_i = 1'b1;
    cyc = 0;
    while (!bus.cmd_ready_o && cyc < 50) begin
      step();
      cyc++;
    end
    n_run++;
    if (bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready_o=%b required 1", bus.cmd_ready_o);
    end
    step();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_addr_i  = 16'hFFFF;
    bus.cmd_data_i  = 32'hFFFFFFFF;
  endtask

  task automatic collect_tx(input bit stall, output logic [7:0][7:0] got, output int stall_bad);
    int n;
    int cyc;
    logic [7:0] held;
    bit stalled;
    n = 0; cyc = 0; held = '0; stalled = 0; got = '0; stall_bad = 0;
    while (n < 8 && cyc < 100) begin
      bus.tx_ready_i = stall ? ~cyc[0] : 1'b1;
      if (bus.tx_valid_o) begin
        if (stalled && bus.tx_data_o !== held) stall_bad++;
        if (bus.tx_ready_i) begin
          got[n] = bus.tx_data_o;
          n++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = bus.tx_data_o;
        end
      end
      step();
      cyc++;
    end
    bus.tx_ready_i = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data_i = b;
    bus.rx_rdy_i  = 1'b1;
    step();
    bus.rx_rdy_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    n_run += 6;
    if (bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready_o); end
    if (bus.tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_txv: got %b want 0", bus.tx_valid_o); end
    if (bus.tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_txd: got %h want 00", bus.tx_data_o); end
    if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rspv: got %b want 0", bus.rsp_valid_o); end
    if (bus.rsp_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_rspd: got %h want 0", bus.rsp_data_o); end
    if (bus.rsp_timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", bus.rsp_timeout_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    logic [7:0][7:0] got;
    int bad;
    send_cmd(1'b0, 16'h1234, 32'h0);
    n_run++;
    if (bus.tx_valid_o !== 1'b1) begin n_fail++; $display("FAIL read_latency: tx_valid_o=%b want 1", bus.tx_valid_o); end
    collect_tx(1'b0, got, bad);
    n_run += 2;
    if (got !== 64'h00000000_123400AA) begin n_fail++; $display("FAIL read_tx: got %h want 00000000123400aa", got); end
    if (bus.tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL read_tx_end: tx_valid_o=%b want 0", bus.tx_valid_o); end
    send_rx(8'hAB); send_rx(8'hEF); send_rx(8'hBE); send_rx(8'hAD); send_rx(8'hDE);
    n_run += 3;
    if (bus.rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL read_rspv: got %b want 1", bus.rsp_valid_o); end
    if (bus.rsp_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rspd: got %h want deadbeef", bus.rsp_data_o); end
    if (bus.rsp_timeout_o !== 1'b0) begin n_fail++; $display("FAIL read_tmo: got %b want 0", bus.rsp_timeout_o); end
    step();
    n_run += 3;
    if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL read_pulse: rsp_valid_o=%b want 0", bus.rsp_valid_o); end
    if (bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL read_idle: cmd_ready_o=%b want 1", bus.cmd_ready_o); end
    if (bus.rsp_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_hold: got %h want deadbeef", bus.rsp_data_o); end
  endtask

  task automatic test_write_stall();
    logic [7:0][7:0] got;
    int bad;
    send_cmd(1'b1, 16'h0002, 32'h01020304);
    collect_tx(1'b1, got, bad);
    n_run += 2;
    if (got !== 64'h01020304_000201AA) begin n_fail++; $display("FAIL write_tx: got %h want 01020304000201aa", got); end
    if (bad !== 0) begin n_fail++; $display("FAIL write_stall_stable: %0d changes while stalled, want 0", bad); end
    send_rx(8'hAB); send_rx(8'h04); send_rx(8'h03); send_rx(8'h02); send_rx(8'h01);
    n_run += 2;
    if (bus.rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL write_rspv: got %b want 1", bus.rsp_valid_o); end
    if (bus.rsp_data_o !== 32'h01020304) begin n_fail++; $display("FAIL write_rspd: got %h want 01020304", bus.rsp_data_o); end
    step();
  endtask

  task automatic test_junk();
    logic [7:0][7:0] got;
    int bad;
    send_cmd(1'b0, 16'h00C0, 32'h0);
    collect_tx(1'b0, got, bad);
    send_rx(8'h55); send_rx(8'hAA); send_rx(8'h00);
    n_run++;
    if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL junk_early: rsp_valid_o=%b want 0", bus.rsp_valid_o); end
    send_rx(8'hAB); send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
    n_run += 2;
    if (bus.rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL junk_rspv: got %b want 1", bus.rsp_valid_o); end
    if (bus.rsp_data_o !== 32'h44332211) begin n_fail++; $display("FAIL junk_rspd: got %h want 44332211", bus.rsp_data_o); end
    step();
  endtask

  task automatic test_timeout();
    logic [7:0][7:0] got;
    int bad;
    int k;
    int hits;
    send_cmd(1'b0, 16'h0010, 32'h0);
    collect_tx(1'b0, got, bad);
`ifdef REG_MASTER_TIMEOUT_EN
    k = 1;
    while (bus.rsp_valid_o !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    n_run += 3;
    if (k !== 16) begin n_fail++; $display("FAIL tmo_latency: rsp after %0d cycles want 16", k); end
    if (bus.rsp_timeout_o !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", bus.rsp_timeout_o); end
    if (bus.rsp_data_o !== 32'h0) begin n_fail++; $display("FAIL tmo_data: got %h want 0", bus.rsp_data_o); end
    step();
    n_run++;
    if (bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL tmo_idle: cmd_ready_o=%b want 1", bus.cmd_ready_o); end
`else
    hits = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.rsp_valid_o !== 1'b0) hits++;
      step();
    end
    n_run += 2;
    if (hits !== 0) begin n_fail++; $display("FAIL notmo_rsp: %0d rsp cycles want 0", hits); end
    if (bus.cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL notmo_busy: cmd_ready_o=%b want 0", bus.cmd_ready_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0][7:0] got;
    int bad;
    int hits;
    send_cmd(1'b1, 16'h5555, 32'h12345678);
    bus.tx_ready_i = 1'b1;
    step(); step(); step();
    bus.tx_ready_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_run += 4;
    if (bus.tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_txv: got %b want 0", bus.tx_valid_o); end
    if (bus.tx_data_o !== 8'h00) begin n_fail++; $display("FAIL rstmid_txd: got %h want 00", bus.tx_data_o); end
    if (bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", bus.cmd_ready_o); end
    if (bus.rsp_data_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_rspd: got %h want 0", bus.rsp_data_o); end
    step(); step();
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid_o !== 1'b0) hits++;
      step();
    end
    n_run++;
    if (hits !== 0) begin n_fail++; $display("FAIL rstmid_norsp: %0d rsp cycles want 0", hits); end
    send_cmd(1'b0, 16'h0BAD, 32'h0);
    collect_tx(1'b0, got, bad);
    n_run++;
    if (got !== 64'h00000000_0BAD00AA) begin n_fail++; $display("FAIL rstmid_tx: got %h want 000000000bad00aa", got); end
    send_rx(8'hAB); send_rx(8'h01); send_rx(8'h00); send_rx(8'h00); send_rx(8'h00);
    n_run += 2;
    if (bus.rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_rspv: got %b want 1", bus.rsp_valid_o); end
    if (bus.rsp_data_o !== 32'h00000001) begin n_fail++; $display("FAIL rstmid_rspd2: got %h want 00000001", bus.rsp_data_o); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0][7:0] got;
    int bad;
    bus.cmd_wr_i    = 1'b0;
    bus.cmd_addr_i  = 16'h00A0;
    bus.cmd_data_i  = 32'h0;
    bus.cmd_valid_i = 1'b1;
    step();
    bus.cmd_wr_i    = 1'b1;
    bus.cmd_addr_i  = 16'h00B1;
    bus.cmd_data_i  = 32'hCAFEF00D;
    collect_tx(1'b0, got, bad);
    n_run++;
    if (got !== 64'h00000000_00A000AA) begin n_fail++; $display("FAIL b2b_tx1: got %h want 0000000000a000aa", got); end
    send_rx(8'hAB); send_rx(8'h78); send_rx(8'h56); send_rx(8'h34); send_rx(8'h12);
    n_run += 3;
    if (bus.rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rspv1: got %b want 1", bus.rsp_valid_o); end
    if (bus.rsp_data_o !== 32'h12345678) begin n_fail++; $display("FAIL b2b_rspd1: got %h want 12345678", bus.rsp_data_o); end
    if (bus.cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done_busy: cmd_ready_o=%b want 0", bus.cmd_ready_o); end
    step();
    n_run++;
    if (bus.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: cmd_ready_o=%b want 1", bus.cmd_ready_o); end
    step();
    bus.cmd_valid_i = 1'b0;
    n_run++;
    if (bus.tx_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_accept2: tx_valid_o=%b want 1", bus.tx_valid_o); end
    collect_tx(1'b0, got, bad);
    n_run++;
    if (got !== 64'hCAFEF00D_00B101AA) begin n_fail++; $display("FAIL b2b_tx2: got %h want cafef00d00b101aa", got); end
    send_rx(8'hAB); send_rx(8'h0D); send_rx(8'hF0); send_rx(8'hFE); send_rx(8'hCA);
    n_run += 2;
    if (bus.rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rspv2: got %b want 1", bus.rsp_valid_o); end
    if (bus.rsp_data_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_rspd2: got %h want cafef00d", bus.rsp_data_o); end
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_read();
    test_write_stall();
    test_junk();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
